csr_mgr_param: RTL and testbench

Parametrised MMIO CSR manager between the CCI-P MMIO request/response path and the application logic. It decodes host MMIO reads and writes, serves a fixed header region (DFH, AFU ID, cycle counter, error counter), and exposes NUM_APP_CSRS generic 64-bit application registers. Unlike the fixed 16-CSR generation, it adds:
- parametrised CSR count
- 32-bit access support, with a write shadow that merges dwords
- per-CSR read-notify strobes
- free-running and error counters

---
 rtl/csr_mgr_pkg.sv | 43 ++++
 rtl/csr_mgr_param_shadow.sv | 33 +++
 rtl/csr_mgr_param.sv | 183 ++++++++++++++++++
 tb/tb_csr_mgr_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_mgr_pkg.sv
// Shared constants, types and header decode helper for the parametrised MMIO CSR manager.
package csr_mgr_pkg;

   localparam int CSR_MGR_COUNTER_BITS = 40;
   typedef logic [CSR_MGR_COUNTER_BITS-1:0] t_csr_mgr_counter;

   localparam logic [63:0] CSR_MGR_DEFAULT_DFH = 64'h1000_0100_0000_0000;

   // Byte offsets of the fixed header region; application CSRs start at OFS_APP_BASE.
   localparam logic [7:0] OFS_DFH      = 8'h00;
   localparam logic [7:0] OFS_AFU_ID_L = 8'h08;
   localparam logic [7:0] OFS_AFU_ID_H = 8'h10;
   localparam logic [7:0] OFS_CYCLE    = 8'h28;
   localparam logic [7:0] OFS_ERR      = 8'h30;
   localparam logic [7:0] OFS_APP_BASE = 8'h40;

   typedef enum logic [2:0] {
      SEL_ZERO,
      SEL_DFH,
      SEL_AFU_L,
      SEL_AFU_H,
      SEL_CYCLE,
      SEL_ERR,
      SEL_APP
   } t_rd_sel;

   function automatic t_rd_sel hdr_sel(input logic [2:0] qword);
      logic [7:0] ofs;
      t_rd_sel    sel;
      ofs = {2'b00, qword, 3'b000};
      sel = SEL_ZERO;
      case (ofs)
         OFS_DFH:      sel = SEL_DFH;
         OFS_AFU_ID_L: sel = SEL_AFU_L;
         OFS_AFU_ID_H: sel = SEL_AFU_H;
         OFS_CYCLE:    sel = SEL_CYCLE;
         OFS_ERR:      sel = SEL_ERR;
         default:      sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/csr_mgr_param_shadow.sv
// One 64-bit application write shadow: full-qword or single-dword merge writes,
// with a one-cycle write pulse aligned to the updated value.
module csr_shadow_reg (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr,
   input  logic        len64,
   input  logic        upper,
   input  logic [63:0] data,
   output logic [63:0] shadow,
   output logic        wr_en
);

   // A 32-bit write replaces only the addressed dword and keeps the other half.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow <= '0;
         wr_en  <= 1'b0;
      end else begin
         wr_en <= wr;
         if (wr) begin
            if (len64) begin
               shadow <= data;
            end else if (upper) begin
               shadow[63:32] <= data[31:0];
            end else begin
               shadow[31:0] <= data[31:0];
            end
         end
      end
   end

endmodule

// File: rtl/csr_mgr_param.sv
// Parametrised MMIO CSR manager: header region, NUM_APP_CSRS application shadows,
// two-stage read pipeline, free-running cycle counter and saturating error counter.
module csr_mgr_param
   import csr_mgr_pkg::*;
#(
   parameter int                      NUM_APP_CSRS   = 16,
   parameter int                      MMIO_ADDR_W    = 16,
   parameter int                      COUNTER_BITS   = 40,
   parameter logic [63:0]             DFH_VALUE      = CSR_MGR_DEFAULT_DFH,
   parameter logic [NUM_APP_CSRS-1:0] RD_NOTIFY_MASK = '0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         mmio_req_valid,
   input  logic                         mmio_req_write,
   input  logic [MMIO_ADDR_W-1:0]       mmio_req_addr,
   input  logic                         mmio_req_len64,
   input  logic [8:0]                   mmio_req_tid,
   input  logic [63:0]                  mmio_req_data,
   output logic                         mmio_rsp_valid,
   output logic [8:0]                   mmio_rsp_tid,
   output logic [63:0]                  mmio_rsp_data,
   input  logic [127:0]                 afu_id,
   input  logic [64*NUM_APP_CSRS-1:0]   cpu_rd_data,
   output logic [NUM_APP_CSRS-1:0]      cpu_wr_en,
   output logic [64*NUM_APP_CSRS-1:0]   cpu_wr_data,
   output logic [NUM_APP_CSRS-1:0]      cpu_rd_strobe
);

   localparam int QW_W  = MMIO_ADDR_W - 1;
   localparam int IDX_W = (NUM_APP_CSRS > 1) ? $clog2(NUM_APP_CSRS) : 1;

   localparam logic [QW_W-1:0] APP_BASE_Q = QW_W'(OFS_APP_BASE >> 3);
   localparam logic [QW_W-1:0] APP_END_Q  = APP_BASE_Q + QW_W'(NUM_APP_CSRS);

   logic [QW_W-1:0]         req_qword;
   logic                    req_upper;
   logic                    req_misaligned;
   logic                    req_is_hdr;
   logic                    req_unmapped;
   logic [IDX_W-1:0]        req_idx;
   logic                    req_err;
   logic                    req_app_ok;
   logic                    rd_req;
   t_rd_sel                 req_sel;

   logic [NUM_APP_CSRS-1:0] wr_sel;
   logic [NUM_APP_CSRS-1:0] strobe_next;

   logic                    s1_valid;
   logic [8:0]              s1_tid;
   t_rd_sel                 s1_sel;
   logic [IDX_W-1:0]        s1_idx;
   logic                    s1_len64;
   logic                    s1_upper;

   logic [63:0]             rd_qword;
   logic [63:0]             rsp_next;
   logic [63:0]             rd_words [NUM_APP_CSRS];

   logic [COUNTER_BITS-1:0] cycle_cnt;
   logic [COUNTER_BITS-1:0] err_cnt;

   assign req_qword      = mmio_req_addr[MMIO_ADDR_W-1:1];
   assign req_upper      = mmio_req_addr[0];
   assign req_misaligned = mmio_req_len64 & req_upper;
   assign req_is_hdr     = req_qword < APP_BASE_Q;
   assign req_unmapped   = req_qword >= APP_END_Q;
   assign req_idx        = IDX_W'(req_qword - APP_BASE_Q);
   assign req_err        = mmio_req_valid & (req_unmapped | req_misaligned);
   assign req_app_ok     = mmio_req_valid & ~req_is_hdr & ~req_unmapped & ~req_misaligned;
   assign rd_req         = mmio_req_valid & ~mmio_req_write;

   // Errored reads still travel down the pipeline, just with a zero source.
   always_comb begin
      req_sel = SEL_ZERO;
      if (req_misaligned || req_unmapped) begin
         req_sel = SEL_ZERO;
      end else if (req_is_hdr) begin
         req_sel = hdr_sel(req_qword[2:0]);
      end else begin
         req_sel = SEL_APP;
      end
   end

   // Per-CSR write select and read-notify, both one-hot on the decoded index.
   always_comb begin
      wr_sel      = '0;
      strobe_next = '0;
      for (int i = 0; i < NUM_APP_CSRS; i++) begin
         if (req_app_ok && (req_idx == IDX_W'(i))) begin
            if (mmio_req_write) begin
               wr_sel[i] = 1'b1;
            end else if (RD_NOTIFY_MASK[i]) begin
               strobe_next[i] = 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_APP_CSRS; i++) begin : g_csr
      csr_shadow_reg u_shadow (
         .clk     (clk),
         .reset_n (reset_n),
         .wr      (wr_sel[i]),
         .len64   (mmio_req_len64),
         .upper   (req_upper),
         .data    (mmio_req_data),
         .shadow  (cpu_wr_data[64*i +: 64]),
         .wr_en   (cpu_wr_en[i])
      );
      assign rd_words[i] = cpu_rd_data[64*i +: 64];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid      <= 1'b0;
         s1_tid        <= '0;
         s1_sel        <= SEL_ZERO;
         s1_idx        <= '0;
         s1_len64      <= 1'b0;
         s1_upper      <= 1'b0;
         cpu_rd_strobe <= '0;
      end else begin
         s1_valid      <= rd_req;
         cpu_rd_strobe <= strobe_next;
         if (rd_req) begin
            s1_tid   <= mmio_req_tid;
            s1_sel   <= req_sel;
            s1_idx   <= req_idx;
            s1_len64 <= mmio_req_len64;
            s1_upper <= req_upper;
         end
      end
   end

   // Second stage samples application data and counters at the end of stage 1.
   always_comb begin
      rd_qword = '0;
      case (s1_sel)
         SEL_DFH:   rd_qword = DFH_VALUE;
         SEL_AFU_L: rd_qword = afu_id[63:0];
         SEL_AFU_H: rd_qword = afu_id[127:64];
         SEL_CYCLE: rd_qword = 64'(cycle_cnt);
         SEL_ERR:   rd_qword = 64'(err_cnt);
         SEL_APP:   rd_qword = rd_words[s1_idx];
         default:   rd_qword = '0;
      endcase
      if (s1_len64) begin
         rsp_next = rd_qword;
      end else begin
         rsp_next = {32'h0, s1_upper ? rd_qword[63:32] : rd_qword[31:0]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mmio_rsp_valid <= 1'b0;
         mmio_rsp_tid   <= '0;
         mmio_rsp_data  <= '0;
      end else begin
         mmio_rsp_valid <= s1_valid;
         if (s1_valid) begin
            mmio_rsp_tid  <= s1_tid;
            mmio_rsp_data <= rsp_next;
         end
      end
   end

   // Cycle counter wraps naturally; error counter sticks at all-ones.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         if (req_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_csr_mgr_param.sv
// Self-checking bench for csr_mgr_param: directed scenarios plus randomized accesses
// checked against an address-map level reference model.
module tb_csr_mgr_param;

   localparam int          N      = 4;
   localparam int          CB     = 6;
   localparam logic [3:0]  NOTIFY = 4'b0100;
   localparam logic [63:0] DFH    = 64'h1000_0100_0000_0000;
   localparam int          ERRMAX = (1 << CB) - 1;

   logic           clk;
   logic           reset_n;
   logic           mmio_req_valid;
   logic           mmio_req_write;
   logic [15:0]    mmio_req_addr;
   logic           mmio_req_len64;
   logic [8:0]     mmio_req_tid;
   logic [63:0]    mmio_req_data;
   logic           mmio_rsp_valid;
   logic [8:0]     mmio_rsp_tid;
   logic [63:0]    mmio_rsp_data;
   logic [127:0]   afu_id;
   logic [255:0]   cpu_rd_data;
   logic [3:0]     cpu_wr_en;
   logic [255:0]   cpu_wr_data;
   logic [3:0]     cpu_rd_strobe;

   logic [63:0]    rdVals  [N];
   logic [63:0]    mShadow [N];
   int             mErr;
   int             edges;
   int             tests;
   int             fails;
   int             strobeCount;

   assign cpu_rd_data = {rdVals[3], rdVals[2], rdVals[1], rdVals[0]};

   csr_mgr_param #(
      .NUM_APP_CSRS   (N),
      .MMIO_ADDR_W    (16),
      .COUNTER_BITS   (CB),
      .DFH_VALUE      (DFH),
      .RD_NOTIFY_MASK (NOTIFY)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mmio_req_valid (mmio_req_valid),
      .mmio_req_write (mmio_req_write),
      .mmio_req_addr  (mmio_req_addr),
      .mmio_req_len64 (mmio_req_len64),
      .mmio_req_tid   (mmio_req_tid),
      .mmio_req_data  (mmio_req_data),
      .mmio_rsp_valid (mmio_rsp_valid),
      .mmio_rsp_tid   (mmio_rsp_tid),
      .mmio_rsp_data  (mmio_rsp_data),
      .afu_id         (afu_id),
      .cpu_rd_data    (cpu_rd_data),
      .cpu_wr_en      (cpu_wr_en),
      .cpu_wr_data    (cpu_wr_data),
      .cpu_rd_strobe  (cpu_rd_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock edges seen since reset released; the cycle counter should track this.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) edges <= 0;
      else          edges <= edges + 1;
   end

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] modelRead(input logic [15:0] addr, input logic len64);
      int          q;
      logic [63:0] v;
      q = int'(addr >> 1);
      v = '0;
      if ((len64 && addr[0]) || q >= 8 + N) return 64'h0;
      case (q)
         0:       v = DFH;
         1:       v = afu_id[63:0];
         2:       v = afu_id[127:64];
         5:       v = 64'((edges - 1) % (1 << CB));
         6:       v = 64'(mErr);
         default: v = (q >= 8) ? rdVals[q-8] : 64'h0;
      endcase
      if (len64) return v;
      return addr[0] ? {32'h0, v[63:32]} : {32'h0, v[31:0]};
   endfunction

   // One isolated transaction: drive for a cycle, check T+1 effects, then the response at T+2.
   task automatic applyStimulus(input string tag, input logic wr, input logic [15:0] addr,
                                input logic len64, input logic [8:0] tid, input logic [63:0] data);
      int         q;
      logic       isErr;
      logic       ok;
      logic [3:0] expWr;
      logic [3:0] expStb;
      q      = int'(addr >> 1);
      isErr  = (len64 && addr[0]) || (q >= 8 + N);
      ok     = !isErr && (q >= 8);
      expWr  = '0;
      expStb = '0;
      if (ok && wr) begin
         expWr[q-8] = 1'b1;
         if (len64)        mShadow[q-8]        = data;
         else if (addr[0]) mShadow[q-8][63:32] = data[31:0];
         else              mShadow[q-8][31:0]  = data[31:0];
      end
      if (ok && !wr && NOTIFY[q-8]) expStb[q-8] = 1'b1;
      if (isErr && mErr < ERRMAX) mErr++;
      @(negedge clk);
      mmio_req_valid = 1'b1;
      mmio_req_write = wr;
      mmio_req_addr  = addr;
      mmio_req_len64 = len64;
      mmio_req_tid   = tid;
      mmio_req_data  = data;
      @(negedge clk);
      mmio_req_valid = 1'b0;
      checkOutput({tag, ".wr_en"}, 256'(cpu_wr_en), 256'(expWr));
      checkOutput({tag, ".strobe"}, 256'(cpu_rd_strobe), 256'(expStb));
      checkOutput({tag, ".rsp_early"}, 256'(mmio_rsp_valid), 256'(1'b0));
      checkOutput({tag, ".wr_data"}, cpu_wr_data, {mShadow[3], mShadow[2], mShadow[1], mShadow[0]});
      @(negedge clk);
      checkOutput({tag, ".rsp_valid"}, 256'(mmio_rsp_valid), 256'(!wr));
      if (!wr) begin
         checkOutput({tag, ".tid"}, 256'(mmio_rsp_tid), 256'(tid));
         checkOutput({tag, ".data"}, 256'(mmio_rsp_data), 256'(modelRead(addr, len64)));
      end
   endtask

   initial begin
      logic [15:0] a;
      logic        w;
      logic        l;
      tests          = 0;
      fails          = 0;
      strobeCount    = 0;
      mErr           = 0;
      reset_n        = 1'b0;
      mmio_req_valid = 1'b0;
      mmio_req_write = 1'b0;
      mmio_req_addr  = '0;
      mmio_req_len64 = 1'b0;
      mmio_req_tid   = '0;
      mmio_req_data  = '0;
      afu_id         = 128'hAABB_CCDD_EEFF_1122_3344_5566_7788_0011;
      for (int j = 0; j < N; j++) begin
         rdVals[j]  = {$urandom, $urandom};
         mShadow[j] = '0;
      end
      repeat (3) @(negedge clk);
      checkOutput("reset.rsp_valid", 256'(mmio_rsp_valid), 256'(1'b0));
      checkOutput("reset.wr_data", cpu_wr_data, 256'h0);
      checkOutput("reset.strobe", 256'(cpu_rd_strobe), 256'h0);
      reset_n = 1'b1;

      applyStimulus("hdr.afu_h", 1'b0, 16'h0004, 1'b1, 9'h1A5, 64'h0);
      applyStimulus("hdr.dfh", 1'b0, 16'h0000, 1'b1, 9'h003, 64'h0);
      applyStimulus("hdr.afu_l32", 1'b0, 16'h0003, 1'b0, 9'h004, 64'h0);

      applyStimulus("merge.w64", 1'b1, 16'h0012, 1'b1, 9'h0, 64'h1111_2222_3333_4444);
      applyStimulus("merge.w32", 1'b1, 16'h0013, 1'b0, 9'h0, 64'h5555_6666_DEAD_BEEF);
      checkOutput("merge.shadow1", 256'(cpu_wr_data[127:64]), 256'(64'hDEAD_BEEF_3333_4444));

      applyStimulus("unmap.rd", 1'b0, 16'h0018, 1'b1, 9'h010, 64'h0);
      applyStimulus("unmap.err1", 1'b0, 16'h000C, 1'b1, 9'h011, 64'h0);
      applyStimulus("misal.wr", 1'b1, 16'h0011, 1'b1, 9'h0, 64'hFFFF_0000_FFFF_0000);
      applyStimulus("misal.err2", 1'b0, 16'h000C, 1'b1, 9'h012, 64'h0);
      applyStimulus("hdr.wr_ignored", 1'b1, 16'h0002, 1'b1, 9'h0, 64'h1234_5678_9ABC_DEF0);

      // Back-to-back reads of CSRs 2, 3, 2; only CSR 2 has read notify enabled.
      @(negedge clk);
      mmio_req_valid = 1'b1; mmio_req_write = 1'b0; mmio_req_len64 = 1'b1;
      mmio_req_addr  = 16'h0014; mmio_req_tid = 9'h021;
      @(negedge clk);
      strobeCount += int'(cpu_rd_strobe[2]);
      checkOutput("pipe.stb1", 256'(cpu_rd_strobe), 256'(4'b0100));
      checkOutput("pipe.rv0", 256'(mmio_rsp_valid), 256'(1'b0));
      mmio_req_addr = 16'h0016; mmio_req_tid = 9'h022;
      @(negedge clk);
      strobeCount += int'(cpu_rd_strobe[2]);
      checkOutput("pipe.stb2", 256'(cpu_rd_strobe), 256'(4'b0000));
      checkOutput("pipe.rsp1", {mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data}, {1'b1, 9'h021, rdVals[2]});
      mmio_req_addr = 16'h0014; mmio_req_tid = 9'h023;
      @(negedge clk);
      mmio_req_valid = 1'b0;
      strobeCount += int'(cpu_rd_strobe[2]);
      checkOutput("pipe.stb3", 256'(cpu_rd_strobe), 256'(4'b0100));
      checkOutput("pipe.rsp2", {mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data}, {1'b1, 9'h022, rdVals[3]});
      @(negedge clk);
      checkOutput("pipe.rsp3", {mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data}, {1'b1, 9'h023, rdVals[2]});
      checkOutput("pipe.stb_idle", 256'(cpu_rd_strobe), 256'h0);
      @(negedge clk);
      checkOutput("pipe.rv_end", 256'(mmio_rsp_valid), 256'(1'b0));
      checkOutput("pipe.strobe_count", 256'(strobeCount), 256'(2));

      for (int k = 0; k < 60; k++) begin
         a = 16'($urandom_range(0, 31));
         w = 1'($urandom_range(0, 1));
         l = 1'($urandom_range(0, 1));
         if (k % 10 == 0) begin
            for (int j = 0; j < N; j++) rdVals[j] = {$urandom, $urandom};
         end
         applyStimulus("rand", w, a, l, 9'($urandom), {$urandom, $urandom});
      end
      applyStimulus("cycle.read", 1'b0, 16'h000A, 1'b1, 9'h0AA, 64'h0);

      repeat (70) applyStimulus("sat.wr", 1'b1, 16'h0040, 1'b0, 9'h0, 64'h0);
      applyStimulus("sat.err", 1'b0, 16'h000C, 1'b1, 9'h0BB, 64'h0);
      checkOutput("sat.model", 256'(mErr), 256'(ERRMAX));

      // Reset asserted one cycle into a notified read: nothing may come out.
      @(negedge clk);
      mmio_req_valid = 1'b1; mmio_req_write = 1'b0; mmio_req_len64 = 1'b1;
      mmio_req_addr  = 16'h0014; mmio_req_tid = 9'h077;
      @(negedge clk);
      mmio_req_valid = 1'b0;
      reset_n        = 1'b0;
      #1;
      checkOutput("rst.outputs", {mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, cpu_wr_en, cpu_rd_strobe},
                  {1'b0, 9'h0, 64'h0, 4'h0, 4'h0});
      checkOutput("rst.wr_data", cpu_wr_data, 256'h0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst.no_rsp", 256'(mmio_rsp_valid), 256'(1'b0));
      for (int j = 0; j < N; j++) mShadow[j] = '0;
      mErr    = 0;
      reset_n = 1'b1;
      applyStimulus("rst.cycle", 1'b0, 16'h000A, 1'b1, 9'h0CC, 64'h0);
      applyStimulus("rst.err", 1'b0, 16'h000C, 1'b1, 9'h0CD, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
